// File: rtl/cues_fc_pkg.sv
// rtl/cues_fc_pkg.sv - shared FC-stage widths, token struct and occupancy encoding
package cues_fc_pkg;

  localparam int DEF_NODE_W = 16;
  localparam int DEF_GEN_W  = 12;
  localparam int DEF_OPR_W  = 32;
  localparam int DEF_WEN_W  = 2;

  // Canonical pair as seen by the CPMer: opr0 is always the left operand.
  typedef struct packed {
    logic [DEF_NODE_W-1:0] node;
    logic [DEF_GEN_W-1:0]  gen;
    logic [DEF_OPR_W-1:0]  opr0;
    logic [DEF_OPR_W-1:0]  opr1;
    logic [DEF_WEN_W-1:0]  mem_wen;
  } fc_token_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fc_skid_buf.sv
// rtl/fc_skid_buf.sv - generic 2-entry valid/ready FIFO (head + skid) over a packed payload
module fc_skid_buf
  import cues_fc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  occ_state_e state;
  occ_state_e state_nxt;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic push;
  logic pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OCC_EMPTY: if (push) state_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop) begin
          state_nxt = OCC_FULL;
        end else if (!push && pop) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: if (pop) state_nxt = OCC_ONE;
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // Ready depends only on registered state, so no out_ready -> in_ready path exists.
  always_comb begin
    in_ready  = (state != OCC_FULL);
    out_valid = (state != OCC_EMPTY);
    occ       = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      unique case (state)
        OCC_EMPTY: if (push) head <= in_data;
        OCC_ONE: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            skid <= in_data;
          end
        end
        OCC_FULL: if (pop) head <= skid;
        default: head <= head;
      endcase
    end
  end

  assign out_data = head;

endmodule

// File: rtl/fc1_pair_stage.sv
// rtl/fc1_pair_stage.sv - elastic FC1 stage: left/right ordering, skid buffer, stall counter
module fc1_pair_stage
  import cues_fc_pkg::*;
#(
  parameter int NODE_W  = DEF_NODE_W,
  parameter int GEN_W   = DEF_GEN_W,
  parameter int OPR_W   = DEF_OPR_W,
  parameter int WEN_W   = DEF_WEN_W,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               lr_i,
  input  logic [NODE_W-1:0]  node_i,
  input  logic [GEN_W-1:0]   gen_i,
  input  logic [OPR_W-1:0]   opr_i,
  input  logic [WEN_W-1:0]   mem_wen_i,
  input  logic [OPR_W-1:0]   mtch_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NODE_W-1:0]  node_o,
  output logic [GEN_W-1:0]   gen_o,
  output logic [OPR_W-1:0]   opr0_o,
  output logic [OPR_W-1:0]   opr1_o,
  output logic [WEN_W-1:0]   mem_wen_o,
  output logic [1:0]         occ_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  input  logic               stall_clr_i
);

  localparam int PAY_W = NODE_W + GEN_W + 2 * OPR_W + WEN_W;

  logic [OPR_W-1:0] opr0_in;
  logic [OPR_W-1:0] opr1_in;
  logic [PAY_W-1:0] in_data;
  logic [PAY_W-1:0] out_data;

  // Ordering is fixed at push so the buffer only ever holds canonical pairs.
  assign opr0_in = lr_i ? mtch_data_i : opr_i;
  assign opr1_in = lr_i ? opr_i : mtch_data_i;
  assign in_data = {node_i, gen_i, opr0_in, opr1_in, mem_wen_i};

  fc_skid_buf #(
    .W(PAY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_data),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_data),
    .occ       (occ_o)
  );

  assign {node_o, gen_o, opr0_o, opr1_o, mem_wen_o} = out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (stall_clr_i) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fc1_pair_stage.sv
// tb/tb_fc1_pair_stage.sv - randomized, scoreboarded bench for fc1_pair_stage
module tb_fc1_pair_stage;

  localparam int NODE_W = 16, GEN_W = 12, OPR_W = 32, WEN_W = 2, STALL_W = 8;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid_i = 1'b0, in_ready_o, lr_i = 1'b0;
  logic [NODE_W-1:0] node_i = '0, node_o;
  logic [GEN_W-1:0] gen_i = '0, gen_o;
  logic [OPR_W-1:0] opr_i = '0, mtch_data_i = '0, opr0_o, opr1_o;
  logic [WEN_W-1:0] mem_wen_i = '0, mem_wen_o;
  logic out_valid_o, out_ready_i = 1'b0;
  logic [1:0] occ_o;
  logic [STALL_W-1:0] stall_cnt_o;
  logic stall_clr_i = 1'b0;

  always #5 clk = ~clk;

  fc1_pair_stage #(
    .NODE_W(NODE_W), .GEN_W(GEN_W), .OPR_W(OPR_W), .WEN_W(WEN_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .lr_i(lr_i),
    .node_i(node_i), .gen_i(gen_i), .opr_i(opr_i), .mem_wen_i(mem_wen_i),
    .mtch_data_i(mtch_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .node_o(node_o), .gen_o(gen_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
    .mem_wen_o(mem_wen_o), .occ_o(occ_o), .stall_cnt_o(stall_cnt_o),
    .stall_clr_i(stall_clr_i)
  );

  typedef struct {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic [WEN_W-1:0]  wen;
  } pair_t;

  pair_t q[$];
  logic [STALL_W-1:0] exp_stall = '0;
  int passed = 0, total = 0;
  int pushed = 0, popped = 0;

  // One clock of stimulus; the model is a 2-deep queue of ordered pairs.
  task automatic tick(input logic v, input logic lr, input logic [NODE_W-1:0] node,
                      input logic [GEN_W-1:0] gen, input logic [OPR_W-1:0] opr,
                      input logic [OPR_W-1:0] mtch, input logic [WEN_W-1:0] wen,
                      input logic rdy, input logic clr, input logic rs);
    pair_t p;
    bit do_push, do_pop, stalled;
    in_valid_i = v; lr_i = lr; node_i = node; gen_i = gen; opr_i = opr;
    mtch_data_i = mtch; mem_wen_i = wen; out_ready_i = rdy; stall_clr_i = clr; rst = rs;
    do_push = v && (q.size() < 2);
    do_pop = (q.size() > 0) && rdy;
    stalled = (q.size() > 0) && !rdy;
    p.node = node; p.gen = gen; p.wen = wen;
    if (lr == 1'b0) begin p.opr0 = opr; p.opr1 = mtch; end
    else begin p.opr0 = mtch; p.opr1 = opr; end
    @(posedge clk); #1;
    if (rs) begin
      q.delete();
      exp_stall = '0;
    end else begin
      if (clr) exp_stall = '0;
      else if (stalled && exp_stall != STALL_MAX) exp_stall = exp_stall + 8'd1;
      if (do_pop) begin void'(q.pop_front()); popped++; end
      if (do_push) begin q.push_back(p); pushed++; end
    end
  endtask

  task automatic push_tok(input logic lr, input logic [OPR_W-1:0] opr,
                          input logic [OPR_W-1:0] mtch, input logic rdy);
    tick(1'b1, lr, 16'h00A5, 12'h03C, opr, mtch, 2'b01, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    tick(1'b0, 1'b0, '0, '0, '0, '0, '0, rdy, clr, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 16'h1234, 12'h456, 32'hDEAD, 32'hBEEF, 2'b11, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 16'h1234, 12'h456, 32'hDEAD, 32'hBEEF, 2'b11, 1'b0, 1'b0, 1'b1);
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid_o); else passed++;
    total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready_o); else passed++;
    total++; if (occ_o !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occ_o); else passed++;
    total++; if (stall_cnt_o !== 8'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); else passed++;
    total++;
    if ({node_o, gen_o, opr0_o, opr1_o, mem_wen_o} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h/%b want all 0", node_o, gen_o, opr0_o, opr1_o, mem_wen_o);
    else passed++;
    idle(1'b0, 1'b0);
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", out_valid_o); else passed++;
  endtask

  task automatic test_ordering();
    push_tok(1'b0, 32'h11, 32'h22, 1'b1);
    total++; if (out_valid_o !== 1'b1) $display("FAIL ord_valid: got %b want 1", out_valid_o); else passed++;
    total++;
    if (opr0_o !== 32'h11 || opr1_o !== 32'h22)
      $display("FAIL ord_left: got opr0=%h opr1=%h want 11/22", opr0_o, opr1_o);
    else passed++;
    total++;
    if (node_o !== 16'h00A5 || gen_o !== 12'h03C || mem_wen_o !== 2'b01)
      $display("FAIL ord_fields: got %h/%h/%b want 00a5/03c/01", node_o, gen_o, mem_wen_o);
    else passed++;
    push_tok(1'b1, 32'h11, 32'h22, 1'b1);
    total++;
    if (opr0_o !== 32'h22 || opr1_o !== 32'h11)
      $display("FAIL ord_right: got opr0=%h opr1=%h want 22/11", opr0_o, opr1_o);
    else passed++;
    total++; if (occ_o !== 2'd1) $display("FAIL ord_pushpop_occ: got %0d want 1", occ_o); else passed++;
    idle(1'b1, 1'b0);
    total++; if (out_valid_o !== 1'b0) $display("FAIL ord_drain: got %b want 0", out_valid_o); else passed++;
  endtask

  task automatic test_stall();
    idle(1'b1, 1'b1);
    push_tok(1'b0, 32'hA0, 32'h1, 1'b0);
    push_tok(1'b0, 32'hB0, 32'h2, 1'b0);
    total++; if (occ_o !== 2'd2) $display("FAIL stall_occ: got %0d want 2", occ_o); else passed++;
    total++; if (in_ready_o !== 1'b0) $display("FAIL stall_ready: got %b want 0", in_ready_o); else passed++;
    push_tok(1'b0, 32'hC0, 32'h3, 1'b0);
    total++; if (opr0_o !== 32'hA0 || occ_o !== 2'd2) $display("FAIL stall_hold: got %h occ %0d want a0 occ 2", opr0_o, occ_o); else passed++;
    total++; if (stall_cnt_o !== 8'd2) $display("FAIL stall_count: got %0d want 2", stall_cnt_o); else passed++;
    push_tok(1'b0, 32'hC0, 32'h3, 1'b1);
    total++; if (opr0_o !== 32'hB0 || in_ready_o !== 1'b1) $display("FAIL stall_rel_b: got %h rdy %b want b0 rdy 1", opr0_o, in_ready_o); else passed++;
    push_tok(1'b0, 32'hC0, 32'h3, 1'b1);
    total++; if (opr0_o !== 32'hC0 || occ_o !== 2'd1) $display("FAIL stall_rel_c: got %h occ %0d want c0 occ 1", opr0_o, occ_o); else passed++;
    idle(1'b1, 1'b0);
    total++; if (out_valid_o !== 1'b0 || stall_cnt_o !== 8'd2) $display("FAIL stall_end: got valid %b cnt %0d want 0/2", out_valid_o, stall_cnt_o); else passed++;
  endtask

  task automatic test_full_pop();
    push_tok(1'b1, 32'h5, 32'h50, 1'b0);
    push_tok(1'b1, 32'h6, 32'h60, 1'b0);
    push_tok(1'b1, 32'h7, 32'h70, 1'b1);
    total++; if (occ_o !== 2'd1 || in_ready_o !== 1'b1) $display("FAIL fullpop_nopush: got occ %0d rdy %b want 1/1", occ_o, in_ready_o); else passed++;
    total++; if (opr0_o !== 32'h60 || opr1_o !== 32'h6) $display("FAIL fullpop_head: got %h/%h want 60/6", opr0_o, opr1_o); else passed++;
    push_tok(1'b1, 32'h7, 32'h70, 1'b1);
    total++; if (opr0_o !== 32'h70 || opr1_o !== 32'h7 || occ_o !== 2'd1) $display("FAIL fullpop_retry: got %h/%h occ %0d want 70/7 occ 1", opr0_o, opr1_o, occ_o); else passed++;
    idle(1'b1, 1'b0);
  endtask

  task automatic test_stall_sat();
    tick(1'b1, 1'b0, 16'h1, 12'h2, 32'h3, 32'h4, 2'b10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 254; i++) idle(1'b0, 1'b0);
    total++; if (stall_cnt_o !== 8'hFE) $display("FAIL sat_preload: got %h want fe", stall_cnt_o); else passed++;
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    total++; if (stall_cnt_o !== 8'hFF) $display("FAIL sat_hold: got %h want ff", stall_cnt_o); else passed++;
    idle(1'b0, 1'b1);
    total++; if (stall_cnt_o !== 8'h00) $display("FAIL sat_clear: got %h want 00", stall_cnt_o); else passed++;
    idle(1'b0, 1'b0);
    total++; if (stall_cnt_o !== 8'h01) $display("FAIL sat_restart: got %h want 01", stall_cnt_o); else passed++;
    idle(1'b1, 1'b1);
  endtask

  task automatic test_midstream_reset();
    push_tok(1'b0, 32'hE1, 32'h1, 1'b0);
    push_tok(1'b0, 32'hE2, 32'h2, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || opr0_o !== '0)
      $display("FAIL midreset_async: got occ %0d valid %b rdy %b opr0 %h want 0/0/1/0", occ_o, out_valid_o, in_ready_o, opr0_o);
    else passed++;
    tick(1'b1, 1'b0, 16'h9, 12'h9, 32'h9, 32'h9, 2'b11, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    total++; if (out_valid_o !== 1'b0) $display("FAIL midreset_release: got %b want 0", out_valid_o); else passed++;
  endtask

  task automatic test_random();
    int push0, pop0, cyc;
    bit ok;
    push0 = pushed; pop0 = popped; cyc = 0;
    while ((pushed - push0) < 10000 && cyc < 40000) begin
      tick($urandom_range(0, 99) < 70, 1'($urandom), 16'($urandom), 12'($urandom),
           32'($urandom), 32'($urandom), 2'($urandom),
           $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 2, 1'b0);
      cyc++;
      total++;
      ok = (occ_o === 2'(q.size())) && (out_valid_o === (q.size() != 0)) && (in_ready_o === (q.size() != 2));
      if (ok && q.size() != 0)
        ok = ({node_o, gen_o, opr0_o, opr1_o, mem_wen_o} ===
              {q[0].node, q[0].gen, q[0].opr0, q[0].opr1, q[0].wen});
      if (!ok)
        $display("FAIL rand_head cyc %0d: got occ %0d %h/%h/%h/%h/%b want occ %0d %h/%h/%h/%h/%b",
                 cyc, occ_o, node_o, gen_o, opr0_o, opr1_o, mem_wen_o, q.size(),
                 q.size() ? q[0].node : '0, q.size() ? q[0].gen : '0,
                 q.size() ? q[0].opr0 : '0, q.size() ? q[0].opr1 : '0, q.size() ? q[0].wen : '0);
      else passed++;
      total++;
      if (stall_cnt_o !== exp_stall) $display("FAIL rand_stall cyc %0d: got %0d want %0d", cyc, stall_cnt_o, exp_stall);
      else passed++;
    end
    total++;
    if ((pushed - push0) != 10000) $display("FAIL rand_budget: got %0d tokens want 10000", pushed - push0);
    else passed++;
    for (int i = 0; i < 4 && q.size() != 0; i++) idle(1'b1, 1'b0);
    total++;
    if (out_valid_o !== 1'b0 || (popped - pop0) != (pushed - push0))
      $display("FAIL rand_drain: got valid %b popped %0d want 0 and %0d", out_valid_o, popped - pop0, pushed - push0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_stall();
    test_full_pop();
    test_stall_sat();
    test_midstream_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
